// File: rtl/jesd_pkg.sv
// Shared JESD204B link-layer constants: control characters, lane states, ILAS layout.
package jesd_pkg;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_7 = 8'hFC;

  localparam int unsigned ILAS_CFG_OCTETS = 14;
  localparam int unsigned ILAS_MF         = 4;

  localparam logic [1:0] ST_CGS       = 2'd0;
  localparam logic [1:0] ST_ILAS_WAIT = 2'd1;
  localparam logic [1:0] ST_ILAS      = 2'd2;
  localparam logic [1:0] ST_DATA      = 2'd3;

  typedef enum logic [1:0] {
    S_CGS       = ST_CGS,
    S_ILAS_WAIT = ST_ILAS_WAIT,
    S_ILAS      = ST_ILAS,
    S_DATA      = ST_DATA
  } lane_state_e;

  // Octet idx of the packed link-config word, octet j at bits [8j+7:8j].
  function automatic logic [7:0] cfg_octet(input logic [8*ILAS_CFG_OCTETS-1:0] cfg,
                                           input logic [3:0] idx);
    return cfg[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/jesd_tx_lane_ctrl_if.sv
// Character-stream and control bundle between the TX lane controller and its environment.
interface jesd_tx_lane_ctrl_if;
  import jesd_pkg::*;

  logic                           i_sync_n;
  logic [7:0]                     i_data;
  logic                           i_data_k;
  logic [8*ILAS_CFG_OCTETS-1:0]   i_ilas_cfg;
  logic                           o_data_ready;
  logic [7:0]                     o_char;
  logic                           o_k;
  logic                           o_rd_en;
  logic                           o_lmfc;
  logic [1:0]                     o_state;
  logic                           o_sync_err;

  // master: the lane controller; slave: user data source and SYNC~ side
  modport master (
    input  i_sync_n, i_data, i_data_k, i_ilas_cfg,
    output o_data_ready, o_char, o_k, o_rd_en, o_lmfc, o_state, o_sync_err
  );

  modport slave (
    output i_sync_n, i_data, i_data_k, i_ilas_cfg,
    input  o_data_ready, o_char, o_k, o_rd_en, o_lmfc, o_state, o_sync_err
  );

endinterface

// File: rtl/jesd_lmfc_counter.sv
// Free-running LMFC octet counter with a registered LMFC pulse and a wrap flag.
module jesd_lmfc_counter #(
  parameter int unsigned FK = 64,
  parameter int unsigned W  = $clog2(FK)
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cnt_o,
  output logic         lmfc_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         lmfc_q, lmfc_d;

  assign wrap_o = (cnt_q == W'(FK - 1));
  assign cnt_d  = wrap_o ? '0 : cnt_q + 1'b1;
  assign lmfc_d = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      lmfc_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lmfc_q <= lmfc_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign lmfc_o = lmfc_q;

endmodule

// File: rtl/jesd_tx_lane_ctrl.sv
// JESD204B TX lane link layer: CGS, ILAS and DATA sequencing of the encoder character stream.
//   state     | meaning
//   CGS       | K28.5 until SYNC~ deasserts
//   ILAS_WAIT | K28.5, waiting for the LMFC boundary
//   ILAS      | four alignment multiframes
//   DATA      | user octets, SYNC~ low-run monitored
module jesd_tx_lane_ctrl
  import jesd_pkg::*;
#(
  parameter int unsigned F        = 2,
  parameter int unsigned K        = 32,
  parameter int unsigned SYNC_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  jesd_tx_lane_ctrl_if.master lane
);

  localparam int unsigned FK     = F * K;
  localparam int unsigned LMFC_W = $clog2(FK);
  localparam int unsigned RUN_W  = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;

  if (FK < 17 || FK > 256 || F < 1 || F > 16 || SYNC_LEN < 1) begin : g_param_err
    $error("jesd_tx_lane_ctrl: illegal parameters F=%0d K=%0d F*K=%0d SYNC_LEN=%0d",
           F, K, FK, SYNC_LEN);
  end

  lane_state_e       state_q, state_d;
  logic [1:0]        mf_q, mf_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [7:0]        char_q, char_d;
  logic              k_q, k_d;
  logic              err_q, err_d;
  logic              rd_en_q;
  logic [LMFC_W-1:0] lmfc_cnt;
  logic              lmfc_wrap;
  logic              lmfc_pulse;

  jesd_lmfc_counter #(
    .FK (FK),
    .W  (LMFC_W)
  ) u_lmfc (
    .clk    (clk),
    .rst    (rst),
    .cnt_o  (lmfc_cnt),
    .lmfc_o (lmfc_pulse),
    .wrap_o (lmfc_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CGS;
      mf_q    <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      mf_q    <= mf_d;
      run_q   <= run_d;
    end
  end

  // Loss of SYNC~ always wins over the multiframe advance.
  always_comb begin
    state_d = state_q;
    mf_d    = mf_q;
    run_d   = '0;
    case (state_q)
      S_CGS: begin
        if (lane.i_sync_n) state_d = S_ILAS_WAIT;
      end
      S_ILAS_WAIT: begin
        if (!lane.i_sync_n) begin
          state_d = S_CGS;
        end else if (lmfc_wrap) begin
          state_d = S_ILAS;
          mf_d    = '0;
        end
      end
      S_ILAS: begin
        if (!lane.i_sync_n) begin
          state_d = S_CGS;
          mf_d    = '0;
        end else if (lmfc_wrap) begin
          mf_d = mf_q + 2'd1;
          if (mf_q == 2'(ILAS_MF - 1)) state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!lane.i_sync_n) begin
          if (run_q == RUN_W'(SYNC_LEN - 1)) state_d = S_CGS;
          else                               run_d   = run_q + 1'b1;
        end
      end
      default: state_d = S_CGS;
    endcase
  end

  always_comb begin
    char_d = K28_5;
    k_d    = 1'b1;
    err_d  = 1'b0;
    case (state_q)
      S_ILAS: begin
        char_d = 8'(lmfc_cnt);
        k_d    = 1'b0;
        if (lmfc_cnt == '0) begin
          char_d = K28_0;
          k_d    = 1'b1;
        end else if (lmfc_wrap) begin
          char_d = K28_3;
          k_d    = 1'b1;
        end else if (mf_q == 2'd1 && lmfc_cnt == LMFC_W'(1)) begin
          char_d = K28_4;
          k_d    = 1'b1;
        end else if (mf_q == 2'd1 && lmfc_cnt <= LMFC_W'(ILAS_CFG_OCTETS + 1)) begin
          char_d = cfg_octet(lane.i_ilas_cfg, 4'(lmfc_cnt - LMFC_W'(2)));
        end
      end
      S_DATA: begin
        char_d = lane.i_data;
        k_d    = lane.i_data_k;
        err_d  = lane.i_sync_n && (run_q != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_q  <= K28_5;
      k_q     <= 1'b1;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      char_q  <= char_d;
      k_q     <= k_d;
      err_q   <= err_d;
      rd_en_q <= 1'b1;
    end
  end

  assign lane.o_char       = char_q;
  assign lane.o_k          = k_q;
  assign lane.o_sync_err   = err_q;
  assign lane.o_rd_en      = rd_en_q;
  assign lane.o_lmfc       = lmfc_pulse;
  assign lane.o_state      = state_q;
  assign lane.o_data_ready = (state_q == S_DATA);

endmodule

// File: tb/tb_jesd_tx_lane_ctrl.sv
// Scoreboard bench for jesd_tx_lane_ctrl with F=2, K=32 (64 octets per multiframe).
module tb_jesd_tx_lane_ctrl;

  localparam int FK = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jesd_tx_lane_ctrl_if lane ();

  jesd_tx_lane_ctrl #(
    .F        (2),
    .K        (32),
    .SYNC_LEN (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .lane (lane)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] chr;
    logic       k;
    logic [1:0] st;
    logic       lmfc;
    logic       err;
    logic       rdy;
    logic       rd;
  } exp_t;

  exp_t       sb[$];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] cfg_b [14];

  // Clock edges since the last reset release; tags every expectation.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s stale entry: due cyc=%0d, now cyc=%0d", e.name, e.cyc, cyc);
        end else if (lane.o_char !== e.chr || lane.o_k !== e.k || lane.o_state !== e.st ||
                     lane.o_lmfc !== e.lmfc || lane.o_sync_err !== e.err ||
                     lane.o_data_ready !== e.rdy || lane.o_rd_en !== e.rd) begin
          errors++;
          $display("FAIL %s cyc=%0d got char=%h k=%b st=%0d lmfc=%b err=%b rdy=%b rd=%b want char=%h k=%b st=%0d lmfc=%b err=%b rdy=%b rd=%b",
                   e.name, cyc, lane.o_char, lane.o_k, lane.o_state, lane.o_lmfc,
                   lane.o_sync_err, lane.o_data_ready, lane.o_rd_en,
                   e.chr, e.k, e.st, e.lmfc, e.err, e.rdy, e.rd);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic void push_reset_exp(input string name);
    exp_t e;
    e.cyc = 0; e.name = name; e.chr = 8'hBC; e.k = 1'b1; e.st = 2'd0;
    e.lmfc = 1'b0; e.err = 1'b0; e.rdy = 1'b0; e.rd = 1'b0;
    sb.push_back(e);
  endfunction

  // Drive inputs for the next edge and queue the outputs expected right after it.
  task automatic step(input logic sync, input logic [7:0] d, input logic dk, input string name,
                      input logic [7:0] ech, input logic ek, input logic [1:0] est,
                      input logic eerr);
    exp_t e;
    lane.i_sync_n = sync;
    lane.i_data   = d;
    lane.i_data_k = dk;
    e.cyc  = cyc + 1;
    e.name = name;
    e.chr  = ech;
    e.k    = ek;
    e.st   = est;
    e.lmfc = (((cyc + 1) % FK) == 1);
    e.err  = eerr;
    e.rdy  = (est == 2'd3);
    e.rd   = 1'b1;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic data_step(input logic sync, input logic [7:0] d, input logic dk,
                           input logic eerr, input string name);
    step(sync, d, dk, name, d, dk, 2'd3, eerr);
  endtask

  // Hand rules for ILAS octet n of multiframe m.
  function automatic void ilas_exp(input int m, input int n, output logic [7:0] c,
                                   output logic k);
    k = 1'b0;
    if (n == 0) begin
      c = 8'h1C; k = 1'b1;
    end else if (n == FK - 1) begin
      c = 8'h7C; k = 1'b1;
    end else if (m == 1 && n == 1) begin
      c = 8'h9C; k = 1'b1;
    end else if (m == 1 && n >= 2 && n <= 15) begin
      c = cfg_b[n-2];
    end else begin
      c = 8'(n);
    end
  endfunction

  task automatic enter_ilas(input int n_octets, input string tag);
    logic [7:0] c;
    logic       k;
    step(1'b1, 8'h00, 1'b0, {tag, "_cgs_to_wait"}, 8'hBC, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < FK && (cyc % FK) != FK - 1; i++)
      step(1'b1, 8'h00, 1'b0, {tag, "_wait"}, 8'hBC, 1'b1, 2'd1, 1'b0);
    step(1'b1, 8'h00, 1'b0, {tag, "_wait_to_ilas"}, 8'hBC, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < n_octets; i++) begin
      ilas_exp(i / FK, i % FK, c, k);
      step(1'b1, 8'h00, 1'b0, {tag, "_octet"}, c, k, (i == 4 * FK - 1) ? 2'd3 : 2'd2, 1'b0);
    end
  endtask

  initial begin : stimulus
    logic [7:0] c;
    logic       k;
    for (int j = 0; j < 14; j++) begin
      cfg_b[j] = 8'(j);
      lane.i_ilas_cfg[8*j +: 8] = 8'(j);
    end
    lane.i_sync_n = 1'b0;
    lane.i_data   = 8'h00;
    lane.i_data_k = 1'b0;

    push_reset_exp("reset_values");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    repeat (50) step(1'b0, 8'h00, 1'b0, "cgs_hold", 8'hBC, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < FK && (cyc % FK) != 10; i++)
      step(1'b0, 8'h00, 1'b0, "cgs_hold", 8'hBC, 1'b1, 2'd0, 1'b0);

    enter_ilas(4 * FK, "ilas1");

    data_step(1'b1, 8'hA5, 1'b0, 1'b0, "data_a5");
    data_step(1'b1, 8'h3C, 1'b1, 1'b0, "data_k");
    data_step(1'b1, 8'h00, 1'b0, 1'b0, "data_00");
    data_step(1'b1, 8'hFF, 1'b0, 1'b0, "data_ff");

    data_step(1'b0, 8'h11, 1'b0, 1'b0, "short_low");
    data_step(1'b0, 8'h22, 1'b0, 1'b0, "short_low");
    data_step(1'b1, 8'h33, 1'b0, 1'b1, "sync_err_pulse");
    data_step(1'b1, 8'h44, 1'b0, 1'b0, "sync_err_clear");

    data_step(1'b0, 8'h55, 1'b0, 1'b0, "long_low");
    data_step(1'b0, 8'h66, 1'b0, 1'b0, "long_low");
    data_step(1'b0, 8'h77, 1'b0, 1'b0, "long_low");
    step(1'b0, 8'h88, 1'b0, "long_low_exit", 8'h88, 1'b0, 2'd0, 1'b0);
    repeat (5) step(1'b0, 8'h99, 1'b0, "cgs_after_loss", 8'hBC, 1'b1, 2'd0, 1'b0);

    step(1'b1, 8'h00, 1'b0, "cgs_to_wait", 8'hBC, 1'b1, 2'd1, 1'b0);
    step(1'b0, 8'h00, 1'b0, "wait_to_cgs", 8'hBC, 1'b1, 2'd0, 1'b0);

    enter_ilas(70, "ilas_abort");
    ilas_exp(1, 6, c, k);
    step(1'b0, 8'h00, 1'b0, "ilas_sync_low", c, k, 2'd0, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, "cgs_after_abort", 8'hBC, 1'b1, 2'd0, 1'b0);

    enter_ilas(140, "ilas_pre_rst");
    #2;
    push_reset_exp("mid_ilas_reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    enter_ilas(4 * FK, "ilas_after_rst");
    data_step(1'b1, 8'hC3, 1'b0, 1'b0, "data_after_rst");
    data_step(1'b1, 8'h5A, 1'b1, 1'b0, "data_after_rst_k");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
